// File: rtl/mem_pipe_pkg.sv
// rtl/mem_pipe_pkg.sv - shared request and controller types for mem_pipe
package mem_pipe_pkg;

  typedef enum logic [1:0] {
    Op_INVALID = 2'd0,
    Op_READ    = 2'd1,
    Op_WRITE   = 2'd2
  } Op;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } MemState;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/mem_rsp_pipe.sv
// rtl/mem_rsp_pipe.sv - read response delay line with error flag and data zeroing
module mem_rsp_pipe #(
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic                  in_err,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  rsp_vld,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_data
);

  logic                  vld_q  [READ_LATENCY];
  logic                  err_q  [READ_LATENCY];
  logic [DATA_WIDTH-1:0] data_q [READ_LATENCY];

  logic                  src_vld  [READ_LATENCY];
  logic                  src_err  [READ_LATENCY];
  logic [DATA_WIDTH-1:0] src_data [READ_LATENCY];

  // Stage feeds: stage 0 takes the fresh read (data forced to 0 on error), later stages their predecessor
  always_comb begin
    src_vld[0]  = in_vld;
    src_err[0]  = in_err;
    src_data[0] = in_err ? '0 : in_data;
    for (int i = 1; i < READ_LATENCY; i++) begin
      src_vld[i]  = vld_q[i-1];
      src_err[i]  = err_q[i-1];
      src_data[i] = data_q[i-1];
    end
  end

  // Shift valid every cycle; payload only moves with a valid so the last stage holds between responses
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_q[i]  <= 1'b0;
        err_q[i]  <= 1'b0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_q[i] <= src_vld[i];
        if (src_vld[i]) begin
          err_q[i]  <= src_err[i];
          data_q[i] <= src_data[i];
        end
      end
    end
  end

  assign rsp_vld  = vld_q[READ_LATENCY-1];
  assign rsp_err  = err_q[READ_LATENCY-1];
  assign rsp_data = data_q[READ_LATENCY-1];

endmodule

// File: rtl/mem_pipe.sv
// rtl/mem_pipe.sv - self-clearing byte-writable memory with pipelined reads
module mem_pipe
  import mem_pipe_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 64,
  parameter int ADDR_WIDTH   = 6,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  Op                       req_op,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_data,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    req_rdy,
  output logic                    rsp_vld,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_err
);

  localparam int NB = DATA_WIDTH / BYTE_W;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  MemState state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic accept, in_range, rd_acc, wr_acc;

  assign in_range = 32'(req_addr) < 32'(DEPTH);
  assign accept   = req_rdy && !rst && (req_op != Op_INVALID);
  assign rd_acc   = accept && (req_op == Op_READ);
  assign wr_acc   = accept && (req_op == Op_WRITE) && in_range;

  // Controller state and clear pointer; any reset restarts the sweep at word 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) begin
        clr_ptr <= (clr_ptr == LAST) ? '0 : clr_ptr + 1'b1;
      end
    end
  end

  // Leave CLEAR once the last word is being zeroed; accept requests only in READY
  always_comb begin
    state_d = state_q;
    req_rdy = 1'b0;
    case (state_q)
      CLEAR: if (clr_ptr == LAST) state_d = READY;
      READY: req_rdy = 1'b1;
    endcase
  end

  // Storage: one word zeroed per cycle while clearing, byte-masked writes once ready
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem[clr_ptr] <= '0;
      end else if (wr_acc) begin
        for (int b = 0; b < NB; b++) begin
          if (req_be[b]) mem[req_addr][b*BYTE_W +: BYTE_W] <= req_data[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  mem_rsp_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rsp_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (rd_acc),
    .in_err  (!in_range),
    .in_data (mem[req_addr]),
    .rsp_vld (rsp_vld),
    .rsp_err (rsp_err),
    .rsp_data(rsp_data)
  );

endmodule

// File: tb/tb_mem_pipe.sv
// tb/tb_mem_pipe.sv - randomized and directed checks of mem_pipe at latencies 1, 2 and 4
module tb_mem_pipe;
  import mem_pipe_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 48;
  localparam int AW    = 6;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  Op             req_op   = Op_INVALID;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic [3:0]    req_be   = '0;

  logic          rdy   [3];
  logic          vld   [3];
  logic          err   [3];
  logic [DW-1:0] rdata [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_pipe #(
      .DATA_WIDTH  (DW),
      .DEPTH       (DEPTH),
      .ADDR_WIDTH  (AW),
      .READ_LATENCY(g == 0 ? 1 : (g == 1 ? 2 : 4))
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .req_op  (req_op),
      .req_addr(req_addr),
      .req_data(req_data),
      .req_be  (req_be),
      .req_rdy (rdy[g]),
      .rsp_vld (vld[g]),
      .rsp_data(rdata[g]),
      .rsp_err (err[g])
    );
  end

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
    logic          err;
  } rd_t;

  int            errors = 0;
  int            checks = 0;
  int            cyc    = 0;
  logic [DW-1:0] model_mem [DEPTH];
  int            clr_cnt   = 0;
  bit            model_rdy = 1'b0;
  rd_t           rd_log [$];
  int            ptr       [3];
  logic [DW-1:0] last_data [3];
  logic          last_err  [3];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [DW-1:0] mask;
    if (rst) begin
      model_rdy = 1'b0;
      clr_cnt   = 0;
      for (int k = 0; k < 3; k++) begin
        ptr[k]       = rd_log.size();
        last_data[k] = '0;
        last_err[k]  = 1'b0;
      end
    end else if (!model_rdy) begin
      model_mem[clr_cnt] = '0;
      clr_cnt++;
      if (clr_cnt == DEPTH) model_rdy = 1'b1;
    end else if (req_op != Op_INVALID) begin
      $display("mem received op=%s addr=0x%02h data=0x%08h", req_op.name(), req_addr, req_data);
      if (req_op == Op_WRITE) begin
        if (int'(req_addr) < DEPTH) begin
          mask = {{8{req_be[3]}}, {8{req_be[2]}}, {8{req_be[1]}}, {8{req_be[0]}}};
          model_mem[req_addr] = (model_mem[req_addr] & ~mask) | (req_data & mask);
        end
      end else if (int'(req_addr) < DEPTH) begin
        rd_log.push_back('{cyc, model_mem[req_addr], 1'b0});
      end else begin
        rd_log.push_back('{cyc, '0, 1'b1});
      end
    end
  endtask

  task automatic check_all();
    bit exp_vld;
    for (int k = 0; k < 3; k++) begin
      exp_vld = 1'b0;
      if (ptr[k] < rd_log.size() && (rd_log[ptr[k]].cyc + lat_of(k) - 1 == cyc)) begin
        exp_vld      = 1'b1;
        last_data[k] = rd_log[ptr[k]].data;
        last_err[k]  = rd_log[ptr[k]].err;
        ptr[k]++;
      end
      chk($sformatf("rdy_l%0d@%0d", lat_of(k), cyc), 32'(rdy[k]), 32'(model_rdy));
      chk($sformatf("vld_l%0d@%0d", lat_of(k), cyc), 32'(vld[k]), 32'(exp_vld));
      chk($sformatf("data_l%0d@%0d", lat_of(k), cyc), rdata[k], last_data[k]);
      chk($sformatf("err_l%0d@%0d", lat_of(k), cyc), 32'(err[k]), 32'(last_err[k]));
    end
  endtask

  task automatic step(input bit r, input Op op, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [3:0] be);
    rst      = r;
    req_op   = op;
    req_addr = a;
    req_data = d;
    req_be   = be;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, Op_INVALID, '0, '0, '0);
  endtask

  task automatic rand_step();
    step(1'b0, Op'(2'($urandom_range(0, 2))), AW'($urandom_range(0, 55)),
         $urandom, 4'($urandom_range(0, 15)));
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      ptr[k]       = 0;
      last_data[k] = '0;
      last_err[k]  = 1'b0;
    end

    // reset, then requests during the clear sweep must be ignored
    repeat (3) step(1'b1, Op_INVALID, '0, '0, '0);
    chk("rst_rdy", 32'(rdy[1]), 32'd0);
    chk("rst_data", rdata[1], 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) rand_step();
    chk("rdy_low_47", 32'(rdy[1]), 32'd0);
    rand_step();
    chk("rdy_up_48", 32'(rdy[1]), 32'd1);

    // cleared contents at both ends
    step(1'b0, Op_READ, 6'd0, '0, '0);
    step(1'b0, Op_READ, 6'd47, '0, '0);
    chk("rd0_vld", 32'(vld[1]), 32'd1);
    chk("rd0_data", rdata[1], 32'd0);
    idle(1);
    chk("rd47_data", rdata[1], 32'd0);
    chk("rd47_err", 32'(err[1]), 32'd0);
    idle(4);

    // byte-enable merge
    step(1'b0, Op_WRITE, 6'd5, 32'hDEADBEEF, 4'hF);
    step(1'b0, Op_WRITE, 6'd5, 32'h11223344, 4'h5);
    step(1'b0, Op_READ, 6'd5, '0, '0);
    chk("rd5_early", 32'(vld[1]), 32'd0);
    idle(1);
    chk("rd5_vld", 32'(vld[1]), 32'd1);
    chk("rd5_data", rdata[1], 32'hDE22BE44);
    idle(4);

    // back-to-back reads, all latencies
    step(1'b0, Op_WRITE, 6'd1, 32'hA, 4'hF);
    step(1'b0, Op_WRITE, 6'd2, 32'hB, 4'hF);
    step(1'b0, Op_WRITE, 6'd3, 32'hC, 4'hF);
    step(1'b0, Op_READ, 6'd1, '0, '0);
    step(1'b0, Op_READ, 6'd2, '0, '0);
    step(1'b0, Op_READ, 6'd3, '0, '0);
    chk("b2b_l4_early", 32'(vld[2]), 32'd0);
    idle(5);

    // out-of-range accesses
    step(1'b0, Op_WRITE, 6'd50, 32'h1, 4'hF);
    step(1'b0, Op_READ, 6'd50, '0, '0);
    step(1'b0, Op_READ, 6'd47, '0, '0);
    chk("oor_err", 32'(err[1]), 32'd1);
    chk("oor_data", rdata[1], 32'd0);
    idle(1);
    chk("in_range_err", 32'(err[1]), 32'd0);
    idle(4);

    // invalid ops must not touch memory
    for (int i = 0; i < 10; i++) step(1'b0, Op_INVALID, AW'($urandom_range(0, 47)), $urandom, 4'hF);
    step(1'b0, Op_READ, 6'd5, '0, '0);
    step(1'b0, Op_READ, 6'd1, '0, '0);
    idle(5);

    // random traffic
    for (int i = 0; i < 400; i++) rand_step();
    idle(5);

    // reset with a read in flight, then reset again mid-clear
    step(1'b0, Op_READ, 6'd5, '0, '0);
    step(1'b1, Op_INVALID, '0, '0, '0);
    chk("flush_vld", 32'(vld[1]), 32'd0);
    chk("flush_rdy", 32'(rdy[1]), 32'd0);
    for (int i = 0; i < 20; i++) rand_step();
    step(1'b1, Op_INVALID, '0, '0, '0);
    for (int i = 0; i < DEPTH - 1; i++) rand_step();
    chk("reclear_rdy_low", 32'(rdy[1]), 32'd0);
    rand_step();
    chk("reclear_rdy_up", 32'(rdy[1]), 32'd1);
    for (int i = 0; i < 150; i++) rand_step();
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
